// File: rtl/dlatch_load_ctrl.sv
// Serial-to-parallel loader for a bank of level-sensitive D latches.
// Shifts in a word MSB first, then runs a guarded EN pulse and flags DONE.
module dlatch_load_ctrl #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 2,
   parameter int EN_CYC    = 3,
   parameter int HOLD_CYC  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SDI,
   input  logic             SVALID,
   output logic             SREADY,
   input  logic             CLR,
   output logic [WIDTH-1:0] D,
   output logic             EN,
   output logic             BUSY,
   output logic             DONE
);

   localparam int MAX_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int MAXC   = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
   localparam int PW     = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [PW-1:0] PH_SETUP = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] PH_EN    = PW'(EN_CYC - 1);
   localparam logic [PW-1:0] PH_HOLD  = PW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_SETUP,
      S_ENABLE,
      S_HOLD
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] d_q;
   logic [PW-1:0]    ph_q;
   logic             en_q;
   logic             done_q;

   logic             accept;
   logic             last;
   logic             ph_zero;
   logic [WIDTH-1:0] sr_d;

   assign SREADY  = RST && (state_q == S_IDLE || state_q == S_SHIFT);
   assign accept  = SVALID && SREADY && !CLR;
   assign last    = (cnt_q == CNT_LAST);
   assign ph_zero = (ph_q == '0);
   // New bit enters at the LSB; works for WIDTH=1 as well.
   assign sr_d    = (sr_q << 1) | WIDTH'(SDI);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         d_q     <= '0;
         ph_q    <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ph_q    <= '0;
            en_q    <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE, S_SHIFT: begin
                  if (accept) begin
                     if (last) begin
                        d_q     <= sr_d;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        ph_q    <= PH_SETUP;
                        state_q <= S_SETUP;
                     end else begin
                        sr_q    <= sr_d;
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_SHIFT;
                     end
                  end
               end
               S_SETUP: begin
                  if (ph_zero) begin
                     en_q    <= 1'b1;
                     ph_q    <= PH_EN;
                     state_q <= S_ENABLE;
                  end else begin
                     ph_q <= ph_q - 1'b1;
                  end
               end
               S_ENABLE: begin
                  if (ph_zero) begin
                     en_q    <= 1'b0;
                     ph_q    <= PH_HOLD;
                     state_q <= S_HOLD;
                  end else begin
                     ph_q <= ph_q - 1'b1;
                  end
               end
               S_HOLD: begin
                  if (ph_zero) begin
                     done_q  <= 1'b1;
                     ph_q    <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     ph_q <= ph_q - 1'b1;
                  end
               end
               default: begin
                  en_q    <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign D    = d_q;
   assign EN   = en_q;
   assign DONE = done_q;
   assign BUSY = (state_q == S_SETUP) || (state_q == S_ENABLE) ||
                 (state_q == S_HOLD);

endmodule
